// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction-fill and data-cache requesters.
// Data wins by default; a starvation counter forces an instruction grant after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGRANT = 2'd1;
    localparam logic [1:0] DGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] scnt;
    logic [3:0] next_scnt;
    logic       d_req;

    assign d_req = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            scnt  <= 4'd0;
        end else begin
            state <= next_state;
            scnt  <= next_scnt;
        end
    end

    // RAM outputs are decoded from state so an async reset drops them immediately.
    always_comb begin
        next_state = state;
        next_scnt  = scnt;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        iwait      = 1'b1;
        dwait      = 1'b1;

        case (state)
            IDLE: begin
                if (d_req && !(iREN && scnt == SMAX)) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            DGRANT: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == RAM_ACCESS) begin
                        dwait      = 1'b0;
                        next_state = IDLE;
                        if (iREN) begin
                            next_scnt = (scnt >= SMAX) ? SMAX : scnt + 4'd1;
                        end else begin
                            next_scnt = 4'd0;
                        end
                    end else if (ramstate == RAM_ERROR) begin
                        next_state = IDLE;
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iwait      = 1'b0;
                        next_state = IDLE;
                        next_scnt  = 4'd0;
                    end else if (ramstate == RAM_ERROR) begin
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared against an ownership-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int OWN_NONE  = 0;
    localparam int OWN_INSTR = 1;
    localparam int OWN_DATA  = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        iw;
        logic        dw;
    } outs_t;

    outs_t got;
    outs_t exp_o;
    outs_t reset_o;

    int m_owner;
    int m_wins;

    mem_arbiter #(.STARVE_MAX(STARVE)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    assign got     = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait};
    assign reset_o = {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1};

    // Reference model: who owns the RAM port, and how many data wins an instruction has waited through.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner <= OWN_NONE;
            m_wins  <= 0;
        end else begin
            case (m_owner)
                OWN_NONE: begin
                    if ((dREN || dWEN) && !(iREN && m_wins >= STARVE)) m_owner <= OWN_DATA;
                    else if (iREN) m_owner <= OWN_INSTR;
                end
                OWN_DATA: begin
                    if (!(dREN || dWEN)) begin
                        m_owner <= OWN_NONE;
                    end else if (ramstate == 2'd2) begin
                        m_owner <= OWN_NONE;
                        m_wins  <= iREN ? ((m_wins + 1 > STARVE) ? STARVE : m_wins + 1) : 0;
                    end else if (ramstate == 2'd3) begin
                        m_owner <= OWN_NONE;
                    end
                end
                default: begin
                    if (!iREN) begin
                        m_owner <= OWN_NONE;
                    end else if (ramstate == 2'd2) begin
                        m_owner <= OWN_NONE;
                        m_wins  <= 0;
                    end else if (ramstate == 2'd3) begin
                        m_owner <= OWN_NONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        exp_o    = '0;
        exp_o.iw = 1'b1;
        exp_o.dw = 1'b1;
        if (nRST && m_owner == OWN_DATA && (dREN || dWEN)) begin
            exp_o.addr = daddr;
            if (dWEN) begin
                exp_o.wen   = 1'b1;
                exp_o.store = dstore;
            end else begin
                exp_o.ren = 1'b1;
            end
            exp_o.dw = (ramstate != 2'd2);
        end
        if (nRST && m_owner == OWN_INSTR && iREN) begin
            exp_o.ren  = 1'b1;
            exp_o.addr = iaddr;
            exp_o.iw   = (ramstate != 2'd2);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; iaddr = 32'd0;
        dREN = 1'b0; dWEN = 1'b0; daddr = 32'd0; dstore = 32'd0;
        ramload = 32'd0; ramstate = 2'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        clear_inputs();
        iREN = 1'b1; dREN = 1'b1; ramstate = 2'd2;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if (got !== reset_o)
            $display("[TB] FAIL reset_outputs: got %h expected %h", got, reset_o);
        if (got !== reset_o) n_fail++;
        ramload = 32'hA5A5_5A5A;
        #1;
        n_tests++;
        if (iload !== 32'hA5A5_5A5A || dload !== 32'hA5A5_5A5A) begin
            $display("[TB] FAIL reset_load_passthru: got i=%h d=%h expected a5a55a5a", iload, dload);
            n_fail++;
        end
        do_reset();
    endtask

    task automatic test_lone_fill();
        do_reset();
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1;
        @(negedge CLK);
        n_tests++;
        if (ramREN !== 1'b0) begin
            $display("[TB] FAIL fill_idle_cycle: got ramREN=%b expected 0", ramREN);
            n_fail++;
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            ramstate = 2'd1;
            @(negedge CLK);
            n_tests++;
            if ({ramREN, ramWEN, ramaddr, iwait, dwait} !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b1}) begin
                $display("[TB] FAIL fill_busy: got ren=%b wen=%b addr=%h iw=%b dw=%b expected 1 0 00000040 1 1",
                         ramREN, ramWEN, ramaddr, iwait, dwait);
                n_fail++;
            end
        end
        next_cycle();
        ramstate = 2'd2; ramload = 32'h8C01_0004;
        @(negedge CLK);
        n_tests++;
        if ({iwait, dwait, iload} !== {1'b0, 1'b1, 32'h8C01_0004}) begin
            $display("[TB] FAIL fill_access: got iw=%b dw=%b iload=%h expected 0 1 8c010004", iwait, dwait, iload);
            n_fail++;
        end
        next_cycle();
        iREN = 1'b0; ramstate = 2'd0;
        @(negedge CLK);
        n_tests++;
        if (got !== reset_o) begin
            $display("[TB] FAIL fill_back_idle: got %h expected %h", got, reset_o);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h2000; ramstate = 2'd2;
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        n_tests++;
        if ({ramREN, ramaddr, dwait, iwait} !== {1'b1, 32'h2000, 1'b0, 1'b1}) begin
            $display("[TB] FAIL simul_data_first: got ren=%b addr=%h dw=%b iw=%b expected 1 00002000 0 1",
                     ramREN, ramaddr, dwait, iwait);
            n_fail++;
        end
        next_cycle();
        dREN = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (got !== reset_o) begin
            $display("[TB] FAIL simul_gap_idle: got %h expected %h", got, reset_o);
            n_fail++;
        end
        next_cycle();
        @(negedge CLK);
        n_tests++;
        if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h100, 1'b0, 1'b1}) begin
            $display("[TB] FAIL simul_instr_second: got ren=%b addr=%h iw=%b dw=%b expected 1 00000100 0 1",
                     ramREN, ramaddr, iwait, dwait);
            n_fail++;
        end
        next_cycle();
        iREN = 1'b0;
    endtask

    task automatic test_starvation();
        int seen[$];
        int want[$];
        do_reset();
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600; ramstate = 2'd2;
        for (int k = 0; k < 2 * (STARVE + 2); k++) begin
            @(negedge CLK);
            if (dwait === 1'b0) seen.push_back(OWN_DATA);
            if (iwait === 1'b0) seen.push_back(OWN_INSTR);
            next_cycle();
        end
        for (int k = 0; k < STARVE; k++) want.push_back(OWN_DATA);
        want.push_back(OWN_INSTR);
        want.push_back(OWN_DATA);
        n_tests++;
        if (seen.size() != want.size()) begin
            $display("[TB] FAIL starve_count: got %0d completions expected %0d", seen.size(), want.size());
            n_fail++;
        end else begin
            for (int k = 0; k < want.size(); k++) begin
                n_tests++;
                if (seen[k] != want[k]) begin
                    $display("[TB] FAIL starve_order[%0d]: got owner %0d expected %0d", k, seen[k], want[k]);
                    n_fail++;
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_write();
        do_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3000; dstore = 32'hDEAD_BEEF; ramstate = 2'd1;
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        n_tests++;
        if ({ramREN, ramWEN, ramaddr, ramstore, dwait} !== {1'b0, 1'b1, 32'h3000, 32'hDEAD_BEEF, 1'b1}) begin
            $display("[TB] FAIL write_busy: got ren=%b wen=%b addr=%h store=%h dw=%b expected 0 1 00003000 deadbeef 1",
                     ramREN, ramWEN, ramaddr, ramstore, dwait);
            n_fail++;
        end
        next_cycle();
        ramstate = 2'd2;
        @(negedge CLK);
        n_tests++;
        if ({ramWEN, ramstore, dwait, iwait} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
            $display("[TB] FAIL write_access: got wen=%b store=%h dw=%b iw=%b expected 1 deadbeef 0 1",
                     ramWEN, ramstore, dwait, iwait);
            n_fail++;
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_error_retry();
        int pulses = 0;
        do_reset();
        dREN = 1'b1; daddr = 32'h44; ramstate = 2'd3;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) ramstate = 2'd2;
            if (k == 4) dREN = 1'b0;
            @(negedge CLK);
            if (dwait === 1'b0) pulses++;
            if (k == 1) begin
                n_tests++;
                if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h44, 1'b1}) begin
                    $display("[TB] FAIL error_hold: got ren=%b addr=%h dw=%b expected 1 00000044 1", ramREN, ramaddr, dwait);
                    n_fail++;
                end
            end
            if (k == 2) begin
                n_tests++;
                if (got !== reset_o) begin
                    $display("[TB] FAIL error_idle_gap: got %h expected %h", got, reset_o);
                    n_fail++;
                end
            end
            if (k == 3) begin
                n_tests++;
                if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h44, 1'b0}) begin
                    $display("[TB] FAIL error_retry_grant: got ren=%b addr=%h dw=%b expected 1 00000044 0", ramREN, ramaddr, dwait);
                    n_fail++;
                end
            end
            next_cycle();
        end
        n_tests++;
        if (pulses != 1) begin
            $display("[TB] FAIL error_pulse_count: got %0d expected 1", pulses);
            n_fail++;
        end
        clear_inputs();
    endtask

    task automatic test_abort();
        do_reset();
        iREN = 1'b1; iaddr = 32'h88; ramstate = 2'd1;
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        next_cycle();
        iREN = 1'b0; ramstate = 2'd2;
        @(negedge CLK);
        n_tests++;
        if ({ramREN, iwait} !== {1'b0, 1'b1}) begin
            $display("[TB] FAIL abort_withdraw: got ren=%b iw=%b expected 0 1", ramREN, iwait);
            n_fail++;
        end
        do_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; ramstate = 2'd1;
        @(negedge CLK);
        next_cycle();
        #2;
        nRST = 1'b0;
        #1;
        n_tests++;
        if (got !== reset_o) begin
            $display("[TB] FAIL abort_async_reset: got %h expected %h", got, reset_o);
            n_fail++;
        end
        @(negedge CLK);
        nRST = 1'b1;
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = ~dREN;
            if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 7) == 0) iaddr = $urandom;
            if ($urandom_range(0, 7) == 0) daddr = $urandom;
            if ($urandom_range(0, 7) == 0) dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 9);
            ramstate = (r < 3) ? 2'd1 : (r < 7) ? 2'd2 : (r < 8) ? 2'd3 : 2'd0;
            @(negedge CLK);
            n_tests++;
            if (got !== exp_o) begin
                $display("[TB] FAIL rand_outputs cycle %0d: got %h expected %h", c, got, exp_o);
                n_fail++;
            end
            n_tests++;
            if (iload !== ramload || dload !== ramload || (iwait === 1'b0 && dwait === 1'b0)) begin
                $display("[TB] FAIL rand_loads_waits cycle %0d: got i=%h d=%h iw=%b dw=%b expected loads %h, one wait low at most",
                         c, iload, dload, iwait, dwait, ramload);
                n_fail++;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b1;
        test_reset();
        test_lone_fill();
        test_simultaneous();
        test_starvation();
        test_write();
        test_error_retry();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
